vga_sync_gen: RTL

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock. Produces a 25 MHz pixel-enable pulse, horizontal/vertical pixel counters, active-low sync pulses and a display-area flag. Sits directly upstream of the pixel colour generator, which consumes `x`, `y` and `video_on` and returns 1-bit r/g/b per pixel.

---
 rtl/vga_timing_pkg.sv | 46 ++++
 rtl/pixel_tick_div.sv | 36 +++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480 @ 60 Hz VGA timing constants. Used by vga_sync_gen for its
// default geometry and by the downstream pixel colour generator for the
// visible-area limits (X_MAX / Y_MAX).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // System clocks per pixel (100 MHz board clock / 25 MHz pixel rate)
  localparam int CLK_DIV   = 4;

  // Horizontal geometry, in pixels
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_RETRACE = 96;
  localparam int H_BACK    = 48;

  // Vertical geometry, in lines
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_RETRACE = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;  // 800
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;  // 525

  // Inclusive sync-pulse bounds
  localparam int HS_START  = H_DISPLAY + H_FRONT;                       // 656
  localparam int HS_END    = HS_START + H_RETRACE - 1;                  // 751
  localparam int VS_START  = V_DISPLAY + V_FRONT;                       // 490
  localparam int VS_END    = VS_START + V_RETRACE - 1;                  // 491

  // Last visible coordinates
  localparam int X_MAX     = H_DISPLAY - 1;                             // 639
  localparam int Y_MAX     = V_DISPLAY - 1;                             // 479

  // Width of the x/y counters
  localparam int CNT_W     = 10;

  // True when pos lies in the inclusive range [lo, hi]
  function automatic logic in_span(input logic [CNT_W-1:0] pos,
                                   input int lo, input int hi);
    return (pos >= CNT_W'(lo)) && (pos <= CNT_W'(hi));
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// -----------------------------------------------------------------------------
// pixel_tick_div
// Clock-enable divider: asserts p_tick for one clk out of every CLK_DIV.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   p_tick out one-clk enable pulse, decoded from the counter register
// -----------------------------------------------------------------------------
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // Decoded from the register, so the pulse is glitch-free and starts at 0
  // while reset is held.
  assign p_tick = (tick_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA timing generator (640x480 @ 60 Hz by default) running from the 100 MHz
// board clock. Feeds x/y/video_on to the pixel colour generator.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous, active-high
//   p_tick     out one-clk pixel-enable pulse every CLK_DIV clocks
//   x          out horizontal count, 0..H_TOTAL-1
//   y          out vertical count, 0..V_TOTAL-1
//   hsync      out active-low horizontal sync, registered
//   vsync      out active-low vertical sync, registered
//   video_on   out high inside the visible area, registered
//   frame_tick out one-clk pulse on the tick where (x,y) wraps to (0,0)
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_RETRACE = vga_timing_pkg::H_RETRACE,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_RETRACE = vga_timing_pkg::V_RETRACE,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
  localparam int HS_LO = H_DISPLAY + H_FRONT;
  localparam int HS_HI = HS_LO + H_RETRACE - 1;
  localparam int VS_LO = V_DISPLAY + V_FRONT;
  localparam int VS_HI = VS_LO + V_RETRACE - 1;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_last;
  logic             v_last;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  assign h_last = (h_cnt == CNT_W'(H_TOT - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOT - 1));

  // Next-state counters. The sync/video flags are registered from these so
  // they change on exactly the same edge as x/y.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      if (h_last) begin
        h_next = '0;
        if (v_last) begin
          v_next = '0;
        end else begin
          v_next = v_cnt + CNT_W'(1);
        end
      end else begin
        h_next = h_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else begin
      h_cnt    <= h_next;
      v_cnt    <= v_next;
      hsync    <= ~in_span(h_next, HS_LO, HS_HI);
      vsync    <= ~in_span(v_next, VS_LO, VS_HI);
      video_on <= (h_next < CNT_W'(H_DISPLAY)) && (v_next < CNT_W'(V_DISPLAY));
    end
  end

  assign x          = h_cnt;
  assign y          = v_cnt;
  assign frame_tick = p_tick & h_last & v_last;

endmodule
